// File: rtl/tbird_pkg.sv
// Shared types for the tbird tail-light sequencer: sequencer states and the
// lamp pattern shown in each of them.
package tbird_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    HAZ
  } state_e;

  // Bit 0 of each side is the innermost lamp (led1).
  typedef struct packed {
    logic [2:0] left;
    logic [2:0] right;
  } led_t;

  localparam led_t LED_IDLE = '{left: 3'b000, right: 3'b000};
  localparam led_t LED_L1   = '{left: 3'b001, right: 3'b000};
  localparam led_t LED_L2   = '{left: 3'b011, right: 3'b000};
  localparam led_t LED_L3   = '{left: 3'b111, right: 3'b000};
  localparam led_t LED_R1   = '{left: 3'b000, right: 3'b001};
  localparam led_t LED_R2   = '{left: 3'b000, right: 3'b011};
  localparam led_t LED_R3   = '{left: 3'b000, right: 3'b111};
  localparam led_t LED_HAZ  = '{left: 3'b111, right: 3'b111};

  function automatic led_t led_pattern(input state_e s);
    led_t p;
    case (s)
      L1:      p = LED_L1;
      L2:      p = LED_L2;
      L3:      p = LED_L3;
      R1:      p = LED_R1;
      R2:      p = LED_R2;
      R3:      p = LED_R3;
      HAZ:     p = LED_HAZ;
      default: p = LED_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tbird_step_timer.sv
// Step counter for the tbird sequencer: counts 0..STEP_CYCLES-1 and pulses
// tick_o on the terminal count; clear_i holds it at zero.
module tbird_step_timer #(
  parameter int unsigned STEP_CYCLES = 2500
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = ~clear_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tbird.sv
// Thunderbird tail-light sequencer: cumulative outward sweep for turns, all
// six lamps blinking for hazard. Define TBIRD_DEBOUNCE_EN to add a stability
// filter on each synchronized button.
module tbird
  import tbird_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 2500
`ifdef TBIRD_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic right_button,
  input  logic left_button,
  input  logic hazard_button,
  output logic right_led1,
  output logic right_led2,
  output logic right_led3,
  output logic left_led1,
  output logic left_led2,
  output logic left_led3,
  output logic all_leds_on
);

  // Button vectors are ordered {hazard, left, right}, active-low.
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] btn_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {hazard_button, left_button, right_button};
      sync2_q <= sync1_q;
    end
  end

`ifdef TBIRD_DEBOUNCE_EN
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    stable_q, stable_d;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];

  // A differing sample advances the counter; the new level is adopted on the
  // DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DEB_LAST) begin
        stable_d[i] = sync2_q[i];
        dcnt_d[i]   = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stable_q <= '1;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign btn_n = stable_q;
`else
  assign btn_n = sync2_q;
`endif

  logic req_r, req_l, req_h, go_haz;
  assign {req_h, req_l, req_r} = ~btn_n;
  assign go_haz = req_h | (req_l & req_r);

  state_e state_q, state_d, entry_state;
  logic   off_phase_q, off_phase_d;
  logic   tick, timer_clear;

  assign entry_state = go_haz ? HAZ : (req_l ? L1 : (req_r ? R1 : IDLE));
  assign timer_clear = (state_q == IDLE) && !off_phase_q;

  tbird_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear_i(timer_clear),
    .tick_o (tick)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    off_phase_d = off_phase_q;
    case (state_q)
      IDLE: begin
        if (!off_phase_q) begin
          state_d = entry_state;
        end else if (tick) begin
          off_phase_d = 1'b0;
          state_d     = entry_state;
        end
      end
      L1: if (tick) state_d = go_haz ? HAZ : L2;
      L2: if (tick) state_d = go_haz ? HAZ : L3;
      R1: if (tick) state_d = go_haz ? HAZ : R2;
      R2: if (tick) state_d = go_haz ? HAZ : R3;
      L3, R3, HAZ: begin
        if (tick) begin
          state_d     = IDLE;
          off_phase_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        off_phase_d = 1'b0;
      end
    endcase
  end

  led_t led_q;
  logic all_on_q;

  // Lamps are registered from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      off_phase_q <= 1'b0;
      led_q       <= LED_IDLE;
      all_on_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_phase_q <= off_phase_d;
      led_q       <= led_pattern(state_d);
      all_on_q    <= (state_d == HAZ);
    end
  end

  assign left_led1   = led_q.left[0];
  assign left_led2   = led_q.left[1];
  assign left_led3   = led_q.left[2];
  assign right_led1  = led_q.right[0];
  assign right_led2  = led_q.right[1];
  assign right_led3  = led_q.right[2];
  assign all_leds_on = all_on_q;

endmodule

// File: tb/tb_tbird.sv
// Self-checking bench for tbird with STEP_CYCLES=4: per-cycle expected lamp
// vectors are queued as stimulus is applied and compared after each edge.
module tb_tbird;

  logic clock = 1'b0;
  logic reset_n;
  logic right_button, left_button, hazard_button;
  logic right_led1, right_led2, right_led3;
  logic left_led1, left_led2, left_led3;
  logic all_leds_on;

  always #5 clock = ~clock;

  tbird #(
    .STEP_CYCLES(4)
`ifdef TBIRD_DEBOUNCE_EN
    ,
    .DEBOUNCE_CYCLES(16)
`endif
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .right_button (right_button),
    .left_button  (left_button),
    .hazard_button(hazard_button),
    .right_led1   (right_led1),
    .right_led2   (right_led2),
    .right_led3   (right_led3),
    .left_led1    (left_led1),
    .left_led2    (left_led2),
    .left_led3    (left_led3),
    .all_leds_on  (all_leds_on)
  );

  // {all_leds_on, left3..left1, right3..right1}
  localparam logic [6:0] OFF  = 7'b0_000_000;
  localparam logic [6:0] R1   = 7'b0_000_001;
  localparam logic [6:0] R12  = 7'b0_000_011;
  localparam logic [6:0] R123 = 7'b0_000_111;
  localparam logic [6:0] L1   = 7'b0_001_000;
  localparam logic [6:0] L12  = 7'b0_011_000;
  localparam logic [6:0] L123 = 7'b0_111_000;
  localparam logic [6:0] HZ   = 7'b1_111_111;

`ifdef TBIRD_DEBOUNCE_EN
  localparam int PAD = 16;
`else
  localparam int PAD = 0;
`endif

  typedef struct {
    logic [6:0] leds;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [6:0] obs;
  int         total = 0;
  int         bad = 0;

  assign obs = {all_leds_on, left_led3, left_led2, left_led1,
                right_led3, right_led2, right_led1};

  // Entries pushed at a falling edge describe the outputs after each
  // following rising edge, in order.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      total++;
      assert (obs === cur.leds)
      else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", cur.tag, obs, cur.leds);
      end
    end
  end

  task automatic push(input logic [6:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) sb.push_back('{leds: v, tag: tag});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clock);
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL %s_drain: observed=%0d pending expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n       = 1'b0;
    right_button  = 1'b1;
    left_button   = 1'b1;
    hazard_button = 1'b1;
    push(OFF, 2, tag);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    right_button  = 1'b1;
    left_button   = 1'b1;
    hazard_button = 1'b1;
    push(OFF, 2, "reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Right held: 1, 12, 123, off, repeating with period 16.
    right_button = 1'b0;
    push(OFF, 2 + PAD, "right_latency");
    for (int k = 0; k < 2; k++) begin
      push(R1, 4, "right_r1");
      push(R12, 4, "right_r12");
      push(R123, 4, "right_r123");
      push(OFF, 4, "right_off");
    end
    drain("right_held");
    do_reset("reset_after_right");

    // Hazard held: on 4, off 4, repeating; ends lit for a mid-op reset.
    hazard_button = 1'b0;
    push(OFF, 2 + PAD, "haz_latency");
    push(HZ, 4, "haz_on");
    push(OFF, 4, "haz_off");
    push(HZ, 4, "haz_on2");
    push(OFF, 4, "haz_off2");
    push(HZ, 2, "haz_on3");
    drain("haz_held");
    do_reset("reset_mid_haz");

    // Left and right together behave as hazard.
    left_button  = 1'b0;
    right_button = 1'b0;
    push(OFF, 2 + PAD, "both_latency");
    push(HZ, 4, "both_on");
    push(OFF, 4, "both_off");
    push(HZ, 4, "both_on2");
    drain("both_held");
    do_reset("reset_mid_both");

`ifdef TBIRD_DEBOUNCE_EN
    // Short glitch never passes the stability filter.
    left_button = 1'b0;
    push(OFF, 30, "glitch_off");
    repeat (5) @(negedge clock);
    left_button = 1'b1;
    drain("glitch");
    do_reset("reset_after_glitch");

    // Held press lights left_led1 after 3 + 16 clocks.
    left_button = 1'b0;
    push(OFF, 18, "deb_latency");
    push(L1, 4, "deb_l1");
    push(L12, 1, "deb_l12");
    drain("deb_held");
    do_reset("reset_after_deb");
`else
    // One-clock left tap: full sweep, off phase, no repeat.
    left_button = 1'b0;
    push(OFF, 2, "tap_latency");
    push(L1, 4, "tap_l1");
    push(L12, 4, "tap_l12");
    push(L123, 4, "tap_l123");
    push(OFF, 8, "tap_no_repeat");
    @(negedge clock);
    left_button = 1'b1;
    drain("left_tap");

    // Fresh press after a completed off phase starts immediately.
    right_button = 1'b0;
    push(OFF, 2, "fresh_latency");
    push(R1, 4, "fresh_r1");
    push(R12, 1, "fresh_r12");
    drain("fresh_press");
    do_reset("reset_mid_right");

    // Hazard during R2 redirects to HAZ on the next tick.
    right_button = 1'b0;
    push(OFF, 2, "r2haz_latency");
    push(R1, 4, "r2haz_r1");
    push(R12, 4, "r2haz_r12");
    push(HZ, 4, "r2haz_haz");
    push(OFF, 4, "r2haz_off");
    push(HZ, 1, "r2haz_haz2");
    repeat (7) @(negedge clock);
    hazard_button = 1'b0;
    drain("haz_in_r2");
    do_reset("reset_after_r2haz");

    // Right pressed during a left sweep waits for the off phase to end.
    left_button = 1'b0;
    push(OFF, 2, "opp_latency");
    push(L1, 4, "opp_l1");
    push(L12, 4, "opp_l12");
    push(L123, 4, "opp_l123");
    push(OFF, 4, "opp_off");
    push(R1, 4, "opp_r1");
    push(R12, 1, "opp_r12");
    @(negedge clock);
    left_button = 1'b1;
    repeat (4) @(negedge clock);
    right_button = 1'b0;
    drain("opposite_turn");
    do_reset("reset_after_opp");
`endif

    drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tbird.md
Name: tbird

Overview:
- Thunderbird-style tail-light sequencer.
- Three left and three right LEDs light in a cumulative outward sweep for turn signals.
- All six LEDs blink together for hazard.
- Sits between debounced-free push-button inputs (active-low, 50 MHz domain) and the LED output pins; self-contained, no bus interface.

Parameters:
- STEP_CYCLES, 2500, clock cycles per sequence step (50 us at 50 MHz; one full 4-step cycle = 200 us).
- DEBOUNCE_CYCLES, 16, cycles a synchronized button must be stable to be accepted (used only with TBIRD_DEBOUNCE_EN).

Ports:
- clock  input  1  system clock, 50 MHz, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- right_button  input  1  right turn request, active-low (0 = pressed)
- left_button  input  1  left turn request, active-low
- hazard_button  input  1  hazard request, active-low
- right_led1..right_led3  output  1 each  right lamps, active-high, led1 innermost
- left_led1..left_led3  output  1 each  left lamps, active-high, led1 innermost
- all_leds_on  output  1  high exactly when all six LEDs are lit

Behaviour:
- One clock; reset is synchronous and active-low on reset_n. All outputs are registered.
- Reset: state IDLE, step counter 0, all LEDs 0, all_leds_on 0; synchronizers load 1 (released).
- Inputs: each button passes through a 2-flop synchronizer and is inverted to internal active-high req_r, req_l, req_h.
- Request decode: hazard = req_h OR (req_l AND req_r). Otherwise left = req_l, right = req_r.
- States: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
- LED maps:
  - L1 = left_led1.
  - L2 = left_led1,2.
  - L3 = left_led1,2,3.
  - R1..R3 are symmetric on the right LEDs.
  - HAZ = all six LEDs.
  - IDLE = none.
- IDLE step: counter held at 0. On the first cycle a request is seen, the FSM moves to HAZ, L1 or R1 (priority hazard > left > right) and the counter starts.
- Latency: button falling edge to first LED high = 3 clocks (2 sync + 1 state register).
- Step timing: each non-IDLE state lasts exactly STEP_CYCLES clocks. The counter counts 0..STEP_CYCLES-1 and a tick fires on the terminal count, then wraps to 0.
- On tick:
  - L1→L2→L3→IDLE and R1→R2→R3→IDLE.
  - HAZ→IDLE.
  - IDLE then lasts STEP_CYCLES, acting as the off phase. After that, the held request re-enters the first state.
- Continuous hold behaviour:
  - A held turn button gives the period 4×STEP_CYCLES pattern 1, 12, 123, off.
  - A held hazard gives on for STEP_CYCLES, off for STEP_CYCLES, repeating.
- Off-phase counter: after leaving a sequence, IDLE keeps counting for one step before accepting a new request. A fresh press after a completed off phase starts immediately.
- Release mid-sequence: the current turn sequence runs to L3/R3, then IDLE; it does not restart.
- Hazard mid-turn: on the next tick the FSM goes to HAZ instead of the next turn state.
- Opposite turn mid-sequence: ignored until IDLE.
- all_leds_on = 1 only in HAZ.
- Reset mid-operation: reset wins over everything and returns to the IDLE/reset values the next clock.

Optional Feature:
- TBIRD_DEBOUNCE_EN defined: after synchronization, each request is accepted only after DEBOUNCE_CYCLES consecutive identical samples. This adds DEBOUNCE_CYCLES clocks of latency.
- Undefined: synchronizer output feeds decode directly (3-clock latency).

Decomposition:
- tbird_pkg: state enum (IDLE, L1..L3, R1..R3, HAZ) and LED-pattern constants per state.
- Sub-module tbird_step_timer: parameterised counter producing a one-cycle tick, with a clear input held in IDLE-with-no-pending-off-phase.
- FSM, synchronizers and output decode stay in tbird.

Test Plan (STEP_CYCLES=4, macro undefined unless stated):
- Reset: reset_n=0 for 2 clocks, buttons 1 → all LEDs 0, all_leds_on 0.
- Right press held: right_button=0 → right_led1 high at clock 3; after 4 more, led1+2; after 4 more, led1+2+3; then 4 clocks all off; pattern repeats with period 16. Left LEDs stay 0 throughout.
- Left press 1 clock then release at L1 → sequence completes L1, L2, L3, then IDLE, no repeat.
- Hazard held: hazard_button=0 → all six on 4 clocks with all_leds_on=1, off 4 clocks, repeating.
- Left and right both 0 → identical to hazard.
- Hazard asserted during R2 → next tick enters HAZ (all six LEDs on, all_leds_on=1).
- With TBIRD_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - Glitch of 5 clocks on left_button → no LED change.
  - Held press → left_led1 after 3+16 clocks.
